// File: rtl/scale_reg_pkg.sv
// Shared types and default sizes for the scale_reg block.
package scale_reg_pkg;

  localparam int unsigned DefW   = 8;
  localparam int unsigned DefShw = 4;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  typedef enum logic [1:0] {ModeAsr, ModeShl, ModeZero} mode_e;

endpackage

// File: rtl/scale_reg_shifter.sv
// Accumulator with 1-bit ASR/SHL step, sticky SHL overflow and optional saturation.
// Saturation on SHL overflow is enabled by defining SCALE_REG_SAT_EN.
module scale_reg_shifter
  import scale_reg_pkg::*;
#(
  parameter int unsigned W = DefW
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           clr,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] result,
  output logic           ovf
);

  localparam int unsigned AW = 2 * W;

  logic [AW-1:0] acc_q, acc_d;
  mode_e         mode_q, mode_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    acc_d  = acc_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    if (clr) begin
      acc_d  = '0;
      mode_d = ModeZero;
      ovf_d  = 1'b0;
    end else if (load) begin
      ovf_d = 1'b0;
      if (a[W-1]) begin
        mode_d = ModeAsr;
        acc_d  = {{W{a[W-1]}}, a};
      end else if (a != '0) begin
        mode_d = ModeShl;
        acc_d  = {{W{1'b0}}, b};
      end else begin
        mode_d = ModeZero;
        acc_d  = '0;
      end
    end else if (step) begin
      case (mode_q)
        ModeAsr: acc_d = {acc_q[AW-1], acc_q[AW-1:1]};
        ModeShl: begin
          acc_d = {acc_q[AW-2:0], 1'b0};
          // Any 1 leaving the top bit marks the result as overflowed.
          ovf_d = ovf_q | acc_q[AW-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q  <= '0;
      mode_q <= ModeZero;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;

`ifdef SCALE_REG_SAT_EN
  assign result = ovf_q ? {AW{1'b1}} : acc_q;
`else
  assign result = acc_q;
`endif

endmodule

// File: rtl/scale_reg.sv
// Sign-selected scale/shift unit: FSM, shift counter and result register.
// Build option SCALE_REG_SAT_EN saturates SHL overflow (handled in scale_reg_shifter).
module scale_reg
  import scale_reg_pkg::*;
#(
  parameter int unsigned W   = DefW,
  parameter int unsigned SHW = DefShw
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           clr,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [SHW-1:0] k,
  input  logic           ld,
  input  logic [2*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic [2*W-1:0] outC
);

  state_e         state_q, state_d;
  logic [SHW-1:0] count_q, count_d;
  logic [2*W-1:0] outc_q, outc_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;
  logic           load, step;
  logic [2*W-1:0] sh_result;
  logic           sh_ovf;

  scale_reg_shifter #(
    .W (W)
  ) u_shifter (
    .clk    (clk),
    .clr_n  (clr_n),
    .clr    (clr),
    .load   (load),
    .step   (step),
    .a      (a),
    .b      (b),
    .result (sh_result),
    .ovf    (sh_ovf)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    outc_d  = outc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    if (clr) begin
      state_d = StIdle;
      count_d = '0;
      outc_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // start takes precedence over a direct load in the same cycle.
          if (start) begin
            load    = 1'b1;
            count_d = k;
            state_d = ((a != '0) && (k != '0)) ? StShift : StDone;
          end else if (ld) begin
            outc_d = din;
          end
        end
        StShift: begin
          step    = 1'b1;
          count_d = count_q - 1'b1;
          if (count_q == SHW'(1)) state_d = StDone;
        end
        StDone: begin
          outc_d  = sh_result;
          ovf_d   = sh_ovf;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      count_q <= '0;
      outc_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      outc_q  <= outc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign outC = outc_q;

endmodule

// File: tb/tb_scale_reg.sv
// Directed bench for scale_reg (W=8, SHW=4); honours SCALE_REG_SAT_EN for expectations.
module tb_scale_reg;

  logic        clk;
  logic        clr_n;
  logic        clr;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  k;
  logic        ld;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] outC;

  int checks = 0;
  int errors = 0;

  scale_reg #(
    .W   (8),
    .SHW (4)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (clr),
    .start (start),
    .a     (a),
    .b     (b),
    .k     (k),
    .ld    (ld),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .outC  (outC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  k;
    logic [15:0] out_wrap;
    logic [15:0] out_sat;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done after E0; lat is edges from E0, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("busy_low_at_done", busy, 0);
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tk,
                       output int lat);
    @(negedge clk);
    a = ta;
    b = tb;
    k = tk;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_e0", busy, 1);
    check("done_single_pulse", done, 0);
    wait_done(lat);
  endtask

  function automatic logic [15:0] exp_out(input logic [15:0] w, input logic [15:0] s);
`ifdef SCALE_REG_SAT_EN
    return s;
`else
    return w;
`endif
  endfunction

  initial begin
    int lat;

    vecs[0] = '{8'hFB, 8'h00, 4'd1,  16'hFFFD, 16'hFFFD, 1'b0, 2};
    vecs[1] = '{8'h03, 8'h81, 4'd3,  16'h0408, 16'h0408, 1'b0, 4};
    vecs[2] = '{8'h00, 8'hFF, 4'd9,  16'h0000, 16'h0000, 1'b0, 1};
    vecs[3] = '{8'h01, 8'hFF, 4'd15, 16'h8000, 16'hFFFF, 1'b1, 16};
    vecs[4] = '{8'h80, 8'h00, 4'd15, 16'hFFFF, 16'hFFFF, 1'b0, 16};
    vecs[5] = '{8'h7F, 8'h01, 4'd0,  16'h0001, 16'h0001, 1'b0, 1};
    vecs[6] = '{8'h01, 8'h80, 4'd8,  16'h8000, 16'h8000, 1'b0, 9};
    vecs[7] = '{8'h01, 8'h80, 4'd9,  16'h0000, 16'hFFFF, 1'b1, 10};
    vecs[8] = '{8'hFF, 8'h00, 4'd4,  16'hFFFF, 16'hFFFF, 1'b0, 5};
    vecs[9] = '{8'h40, 8'h03, 4'd2,  16'h000C, 16'h000C, 1'b0, 3};

    clr_n = 1'b0;
    clr   = 1'b0;
    start = 1'b0;
    ld    = 1'b0;
    a     = '0;
    b     = '0;
    k     = '0;
    din   = '0;
    #1;
    check("reset_outC", outC, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovf", ovf, 0);
    @(negedge clk);
    clr_n = 1'b1;

    // Table: each op starts on the first edge after the previous one ends.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].k, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_outC", i), outC, exp_out(vecs[i].out_wrap, vecs[i].out_sat));
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
    end

    // Direct load in IDLE keeps ovf and raises no done.
    do_op(8'h01, 8'hFF, 4'd15, lat);
    @(negedge clk);
    ld  = 1'b1;
    din = 16'h1234;
    @(posedge clk);
    #1;
    ld = 1'b0;
    check("ld_outC", outC, 16'h1234);
    check("ld_ovf_kept", ovf, 1);
    check("ld_no_done", done, 0);

    // ld and start while busy are both ignored.
    @(negedge clk);
    a = 8'h01;
    b = 8'h01;
    k = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    ld    = 1'b1;
    din   = 16'hABCD;
    start = 1'b1;
    a     = 8'h00;
    k     = 4'd0;
    @(posedge clk);
    #1;
    ld    = 1'b0;
    start = 1'b0;
    check("busy_ld_ignored", outC, 16'h1234);
    check("busy_still", busy, 1);
    wait_done(lat);
    lat = lat + 1;
    check("busy_op_lat", lat, 4);
    check("busy_op_outC", outC, 16'h0008);

    // ld and start together: start wins.
    @(negedge clk);
    a     = 8'h00;
    b     = 8'h00;
    k     = 4'd0;
    din   = 16'h5555;
    ld    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    ld    = 1'b0;
    start = 1'b0;
    wait_done(lat);
    check("ld_start_lat", lat, 1);
    check("ld_start_outC", outC, 16'h0000);

    // Synchronous clear mid-SHIFT.
    do_op(8'h01, 8'hFF, 4'd15, lat);
    @(negedge clk);
    a = 8'h01;
    b = 8'h01;
    k = 4'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("clr_pre_done_e1", done, 0);
    @(posedge clk);
    #1;
    check("clr_pre_done_e2", done, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_outC", outC, 0);
    check("clr_ovf", ovf, 0);
    check("clr_done", done, 0);
    do_op(8'hFB, 8'h00, 4'd1, lat);
    check("after_clr_lat", lat, 2);
    check("after_clr_outC", outC, 16'hFFFD);

    // Asynchronous reset mid-SHIFT, no clock edge needed.
    do_op(8'h01, 8'hFF, 4'd15, lat);
    @(negedge clk);
    a = 8'h01;
    b = 8'h01;
    k = 4'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check("arst_outC", outC, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ovf", ovf, 0);
    @(negedge clk);
    clr_n = 1'b1;
    do_op(8'h03, 8'h81, 4'd3, lat);
    check("after_arst_lat", lat, 4);
    check("after_arst_outC", outC, 16'h0408);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
